// File: rtl/wb_arbiter_pkg.sv
// Shared types and the round-robin search used by the Wishbone arbiter.
package wb_arbiter_pkg;

  localparam int unsigned MAX_MASTERS = 8;
  localparam int unsigned MAX_IDX_W   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    TERM = 2'd2
  } arb_state_e;

  // First requester found searching upward from last+1, wrapping at n.
  function automatic logic [MAX_MASTERS-1:0] rr_next_grant(
    input logic [MAX_MASTERS-1:0] req,
    input logic [MAX_IDX_W-1:0]   last,
    input int unsigned            n
  );
    logic [MAX_MASTERS-1:0] grant;
    int unsigned            idx;
    grant = '0;
    for (int unsigned k = 1; k <= MAX_MASTERS; k++) begin
      idx = (32'(last) + k) % n;
      if (k <= n && grant == '0 && req[MAX_IDX_W'(idx)]) begin
        grant[MAX_IDX_W'(idx)] = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/wb_if.sv
// Wishbone classic bus bundle; master drives the request, slave drives the response.
interface wb_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8;

  logic                  cyc;
  logic                  stb;
  logic                  we;
  logic [ADDR_WIDTH-1:0] adr;
  logic [SEL_WIDTH-1:0]  sel;
  logic [DATA_WIDTH-1:0] dat_w;
  logic [DATA_WIDTH-1:0] dat_r;
  logic                  ack;
  logic                  err;

  modport master (output cyc, stb, we, adr, sel, dat_w, input ack, err, dat_r);
  modport slave  (input cyc, stb, we, adr, sel, dat_w, output ack, err, dat_r);
endinterface

// File: rtl/wb_rr_prio.sv
// Combinational round-robin priority search: request vector + last grant in, one-hot grant out.
module wb_rr_prio
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [N-1:0]         gnt_c
);

  logic [MAX_MASTERS-1:0] gnt_ext;

  assign gnt_ext = rr_next_grant(MAX_MASTERS'(req), MAX_IDX_W'(last), N);
  assign gnt_c   = gnt_ext[N-1:0];

  if (N < MAX_MASTERS) begin : g_pad
    logic unused_hi;
    assign unused_hi = |gnt_ext[MAX_MASTERS-1:N];
  end

endmodule

// File: rtl/wb_arbiter_rr.sv
// Round-robin arbiter sharing one Wishbone slave among N_MASTERS masters.
// Define WB_ARBITER_TIMEOUT_EN to add the stalled-transfer watchdog (TERM state).
module wb_arbiter_rr
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned N_MASTERS      = 2,
  parameter int unsigned WB_ADDR_WIDTH  = 32,
  parameter int unsigned WB_DATA_WIDTH  = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                 clk,
  input  logic                 rstn,
  wb_if.slave                  m [N_MASTERS],
  wb_if.master                 s,
  output logic [N_MASTERS-1:0] gnt,
  output logic                 timeout
);

  localparam int unsigned SEL_W = WB_DATA_WIDTH / 8;
  localparam int unsigned IDX_W = $clog2(N_MASTERS);

  arb_state_e                 state_q, state_d;
  logic [N_MASTERS-1:0]       gnt_d, pick_c;
  logic [IDX_W-1:0]           last_q, last_d, gnt_idx;
  logic [N_MASTERS-1:0]       m_cyc, m_stb, m_we;
  logic [WB_ADDR_WIDTH-1:0]   m_adr [N_MASTERS];
  logic [SEL_W-1:0]           m_sel [N_MASTERS];
  logic [WB_DATA_WIDTH-1:0]   m_dat [N_MASTERS];
  logic                       sel_cyc, sel_stb, sel_we;
  logic [WB_ADDR_WIDTH-1:0]   sel_adr;
  logic [SEL_W-1:0]           sel_sel;
  logic [WB_DATA_WIDTH-1:0]   sel_dat;
  logic                       busy, term;

  assign busy = (state_q == BUSY);
  assign term = (state_q == TERM);

  // Flatten the port array; responses reach only the granted master.
  for (genvar i = 0; i < N_MASTERS; i++) begin : g_port
    assign m_cyc[i]   = m[i].cyc;
    assign m_stb[i]   = m[i].stb;
    assign m_we[i]    = m[i].we;
    assign m_adr[i]   = m[i].adr;
    assign m_sel[i]   = m[i].sel;
    assign m_dat[i]   = m[i].dat_w;
    assign m[i].ack   = gnt[i] & ~term & s.ack;
    assign m[i].err   = gnt[i] & (term | s.err);
    assign m[i].dat_r = (gnt[i] & ~term) ? s.dat_r : '0;
  end

  always_comb begin
    sel_cyc = 1'b0;
    sel_stb = 1'b0;
    sel_we  = 1'b0;
    sel_adr = '0;
    sel_sel = '0;
    sel_dat = '0;
    gnt_idx = '0;
    for (int i = 0; i < int'(N_MASTERS); i++) begin
      if (gnt[i]) begin
        sel_cyc = m_cyc[i];
        sel_stb = m_stb[i];
        sel_we  = m_we[i];
        sel_adr = m_adr[i];
        sel_sel = m_sel[i];
        sel_dat = m_dat[i];
        gnt_idx = IDX_W'(i);
      end
    end
  end

  assign s.cyc   = sel_cyc & busy;
  assign s.stb   = sel_stb & busy;
  assign s.we    = sel_we;
  assign s.adr   = sel_adr;
  assign s.sel   = sel_sel;
  assign s.dat_w = sel_dat;

  wb_rr_prio #(.N(N_MASTERS)) u_prio (
    .req   (m_cyc),
    .last  (last_q),
    .gnt_c (pick_c)
  );

`ifdef WB_ARBITER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_d;
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt;
    last_d  = last_q;
`ifdef WB_ARBITER_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
`ifdef WB_ARBITER_TIMEOUT_EN
        cnt_d = '0;
`endif
        if (|m_cyc) begin
          state_d = BUSY;
          gnt_d   = pick_c;
        end
      end
      BUSY: begin
        if (!sel_cyc) begin
          state_d = IDLE;
          gnt_d   = '0;
          last_d  = gnt_idx;
        end
`ifdef WB_ARBITER_TIMEOUT_EN
        else if (s.ack || s.err) begin
          cnt_d = '0;
        end else if (sel_stb) begin
          if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_d   = TERM;
            cnt_d     = '0;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`endif
      end
      TERM: begin
        state_d = IDLE;
        gnt_d   = '0;
        last_d  = gnt_idx;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      gnt     <= '0;
      last_q  <= IDX_W'(N_MASTERS - 1);
    end else begin
      state_q <= state_d;
      gnt     <= gnt_d;
      last_q  <= last_d;
    end
  end

`ifdef WB_ARBITER_TIMEOUT_EN
  // Watchdog counter; timeout is high exactly during the TERM cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q   <= '0;
      timeout <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      timeout <= timeout_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Directed bench for wb_arbiter_rr with a per-master response scoreboard.
// Define WB_ARBITER_TIMEOUT_EN to exercise the watchdog path.
module tb_wb_arbiter_rr;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  wb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m_bus [N] ();
  wb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s_bus ();

  logic [N-1:0]  gnt;
  logic          timeout;

  logic [N-1:0]  mc = '0, ms = '0, mw = '0;
  logic [AW-1:0] madr [N];
  logic [DW-1:0] mdw  [N];
  logic [N-1:0]  m_ack, m_err;
  logic [DW-1:0] m_dat_r [N];

  logic slave_en = 1'b1;
  logic err_en   = 1'b0;

  function automatic logic [DW-1:0] smodel(input logic [AW-1:0] a);
    return {16'hC0DE ^ a[31:16], a[15:0]};
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_m
    assign m_bus[g].cyc   = mc[g];
    assign m_bus[g].stb   = ms[g];
    assign m_bus[g].we    = mw[g];
    assign m_bus[g].adr   = madr[g];
    assign m_bus[g].sel   = 4'hF;
    assign m_bus[g].dat_w = mdw[g];
    assign m_ack[g]       = m_bus[g].ack;
    assign m_err[g]       = m_bus[g].err;
    assign m_dat_r[g]     = m_bus[g].dat_r;
  end

  assign s_bus.ack   = slave_en & s_bus.cyc & s_bus.stb;
  assign s_bus.err   = err_en & s_bus.cyc & s_bus.stb;
  assign s_bus.dat_r = smodel(s_bus.adr);

  wb_arbiter_rr #(
    .N_MASTERS(N), .WB_ADDR_WIDTH(AW), .WB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rstn(rstn), .m(m_bus), .s(s_bus), .gnt(gnt), .timeout(timeout)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int tcount   = 0;
  logic [33:0]  q0 [$];
  logic [33:0]  q1 [$];
  logic [N-1:0] glog [$];
  logic [N-1:0] gprev = '0;
  logic chk_slave = 1'b0;
  logic lock_chk  = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Response monitor: every ACK/ERR seen by a master must match its next expectation.
  always @(negedge clk) begin
    logic [33:0] e;
    if (timeout === 1'b1) tcount++;
    if (gnt != '0 && gprev == '0) glog.push_back(gnt);
    gprev = gnt;
    for (int i = 0; i < N; i++) begin
      if (m_ack[i] === 1'b1 || m_err[i] === 1'b1) begin
        if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
          check("resp_unexpected", 64'({m_ack[i], m_err[i]}), 64'd0);
        end else begin
          if (i == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          check("resp", 64'({m_ack[i], m_err[i], m_dat_r[i]}), 64'(e));
        end
      end
    end
  end

  task automatic xfer(input int mi, input logic we, input logic [AW-1:0] adr,
                      input logic [DW-1:0] dat, input int beats,
                      input logic exp_ack, input logic exp_err, output int lat);
    logic got;
    logic [33:0] e;
    lat = -1;
    @(posedge clk); #1;
    mc[mi] = 1'b1; ms[mi] = 1'b1; mw[mi] = we; madr[mi] = adr; mdw[mi] = dat;
    for (int b = 0; b < beats; b++) begin
      e = {exp_ack, exp_err, exp_ack ? smodel(madr[mi]) : 32'h0};
      if (mi == 0) q0.push_back(e);
      else         q1.push_back(e);
      got = 1'b0;
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        if (m_ack[mi] === 1'b1 || m_err[mi] === 1'b1) begin
          got = 1'b1;
          if (b == 0) lat = c;
          break;
        end
      end
      if (!got) check("xfer_no_response", 64'(got), 64'd1);
      if (got && chk_slave) begin
        check("t1_gnt", 64'(gnt), 64'd1);
        check("t1_s_we", 64'(s_bus.we), 64'd1);
        check("t1_s_adr", 64'(s_bus.adr), 64'h100);
        check("t1_s_dat", 64'(s_bus.dat_w), 64'hDEADBEEF);
        check("t1_s_sel", 64'(s_bus.sel), 64'hF);
      end
      if (got && lock_chk && mi == 1) begin
        check("lock_gnt", 64'(gnt), 64'd2);
        check("lock_m0_ack", 64'(m_ack[0]), 64'd0);
        check("lock_m0_datr", 64'(m_dat_r[0]), 64'd0);
      end
      @(posedge clk); #1;
      if (b < beats - 1) begin
        madr[mi] = madr[mi] + 32'd4;
        mdw[mi]  = mdw[mi] + 32'd1;
      end
    end
    mc[mi] = 1'b0; ms[mi] = 1'b0; mw[mi] = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  initial begin
    int lat, lat1;
    for (int i = 0; i < N; i++) begin madr[i] = '0; mdw[i] = '0; end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", 64'(gnt), 64'd0);
    check("rst_timeout", 64'(timeout), 64'd0);
    check("rst_s_cyc", 64'(s_bus.cyc), 64'd0);
    check("rst_s_stb", 64'(s_bus.stb), 64'd0);
    rstn = 1'b1;

    // Single write from m0
    glog.delete();
    chk_slave = 1'b1;
    xfer(0, 1'b1, 32'h100, 32'hDEADBEEF, 1, 1'b1, 1'b0, lat);
    chk_slave = 1'b0;
    check("t1_latency", 64'(lat), 64'd1);
    @(negedge clk);
    check("t1_s_cyc_drop", 64'(s_bus.cyc), 64'd0);
    @(posedge clk); #1;
    check("t1_gnt_idle", 64'(gnt), 64'd0);
    check("t1_glog_size", 64'(glog.size()), 64'd1);

    // Simultaneous ACK and ERR forwarded untouched
    err_en = 1'b1;
    xfer(0, 1'b0, 32'h0000_0200, 32'h0, 1, 1'b1, 1'b1, lat);
    err_en = 1'b0;

    // Alternating grants with both masters always pending
    do_reset();
    glog.delete();
    fork
      begin for (int r = 0; r < 3; r++) xfer(0, 1'b1, 32'h1000 + 32'(r), 32'hA0 + 32'(r), 1, 1'b1, 1'b0, lat); end
      begin for (int r = 0; r < 3; r++) xfer(1, 1'b0, 32'h2000 + 32'(r), 32'h0, 1, 1'b1, 1'b0, lat1); end
    join
    check("rr_glog_size", 64'(glog.size()), 64'd6);
    for (int k = 0; k < 6 && k < glog.size(); k++) begin
      check("rr_grant", 64'(glog[k]), (k % 2 == 0) ? 64'd1 : 64'd2);
    end

    // m1 holds the bus over four read beats while m0 waits
    @(posedge clk);
    glog.delete();
    lock_chk = 1'b1;
    fork
      xfer(1, 1'b0, 32'h0003_0040, 32'h0, 4, 1'b1, 1'b0, lat1);
      begin @(posedge clk); xfer(0, 1'b1, 32'h50, 32'h55, 1, 1'b1, 1'b0, lat); end
    join
    lock_chk = 1'b0;
    check("lock_glog_size", 64'(glog.size()), 64'd2);
    if (glog.size() == 2) begin
      check("lock_first", 64'(glog[0]), 64'd2);
      check("lock_then_m0", 64'(glog[1]), 64'd1);
    end

`ifdef WB_ARBITER_TIMEOUT_EN
    // Slave never responds: watchdog terminates with ERR after TO stalled cycles
    slave_en = 1'b0;
    xfer(0, 1'b0, 32'h400, 32'h0, 1, 1'b0, 1'b1, lat);
    check("to_latency", 64'(lat), 64'(1 + TO));
    check("to_gnt_idle", 64'(gnt), 64'd0);
    check("to_s_cyc", 64'(s_bus.cyc), 64'd0);
    slave_en = 1'b1;
    check("to_pulses", 64'(tcount), 64'd1);
`else
    // Without the watchdog a stalled transfer keeps its grant indefinitely
    slave_en = 1'b0;
    @(posedge clk); #1;
    mc[0] = 1'b1; ms[0] = 1'b1; madr[0] = 32'h400;
    repeat (TO + 4) @(negedge clk);
    check("stall_gnt", 64'(gnt), 64'd1);
    check("stall_err", 64'(m_err[0]), 64'd0);
    mc[0] = 1'b0; ms[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 slave_en = 1'b1;
    check("stall_pulses", 64'(tcount), 64'd0);
`endif

    // Reset asserted mid-burst with m1 granted
    slave_en = 1'b0;
    @(posedge clk); #1;
    mc[1] = 1'b1; ms[1] = 1'b1; madr[1] = 32'h300;
    repeat (2) @(negedge clk);
    check("mid_gnt", 64'(gnt), 64'd2);
    check("mid_s_cyc", 64'(s_bus.cyc), 64'd1);
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_gnt", 64'(gnt), 64'd0);
    check("mid_rst_s_cyc", 64'(s_bus.cyc), 64'd0);
    check("mid_rst_m1_resp", 64'({m_ack[1], m_err[1]}), 64'd0);
    mc[1] = 1'b0; ms[1] = 1'b0;
    slave_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    glog.delete();
    fork
      xfer(0, 1'b1, 32'h500, 32'h77, 1, 1'b1, 1'b0, lat);
      xfer(1, 1'b1, 32'h600, 32'h88, 1, 1'b1, 1'b0, lat1);
    join
    check("post_rst_glog_size", 64'(glog.size()), 64'd2);
    if (glog.size() == 2) begin
      check("post_rst_first", 64'(glog[0]), 64'd1);
      check("post_rst_second", 64'(glog[1]), 64'd2);
    end

    repeat (2) @(posedge clk);
    check("q0_drained", 64'(q0.size()), 64'd0);
    check("q1_drained", 64'(q1.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
